// File: rtl/mb_lane_pattern_comparator.sv
// Receive-side mainband per-lane pattern comparator used during MBINIT.REVERSALMB.
// Each RX lane is compared against a shared 23-bit LFSR reference over a fixed window.
// The block then reports a per-lane pass vector and an aggregate pass flag.
module mb_lane_pattern_comparator #(
    parameter int unsigned NUM_LANES      = 16,
    parameter int unsigned SER_W          = 8,
    parameter int unsigned COMPARE_CYCLES = 64,
    parameter int unsigned ERR_THRESH     = 4,
    parameter logic [22:0] LFSR_SEED      = 23'h1DBFBC
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [1:0]                     i_cw,
    input  logic [NUM_LANES*SER_W-1:0]     i_rx_data,
    input  logic                           i_rx_data_valid,
    output logic [NUM_LANES-1:0]           o_lane_result,
    output logic                           o_compare_done,
    output logic                           o_aggregate_pass
);

    localparam int unsigned LFSR_W = 23;
    localparam int unsigned CNT_W  = $clog2(COMPARE_CYCLES * SER_W + 1);
    localparam int unsigned BEAT_W = $clog2(COMPARE_CYCLES + 1);

    localparam logic [1:0] CW_CLEAR   = 2'b01;
    localparam logic [1:0] CW_COMPARE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                r_state;
    logic [LFSR_W-1:0]     r_lfsr;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [CNT_W-1:0]      r_err_cnt [NUM_LANES];

    logic [SER_W-1:0]      w_ref;
    logic [LFSR_W-1:0]     w_lfsr_next;
    logic [CNT_W-1:0]      w_err_next [NUM_LANES];
    logic [NUM_LANES-1:0]  w_pass_next;
    logic [NUM_LANES-1:0]  w_pass_cur;
    logic [BEAT_W-1:0]     w_beat_inc;
    logic                  w_window_end;

    // One Fibonacci step of x^23+x^21+x^18+x^15+x^7+x^2+1, shifting left with feedback into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[22] ^ s[20] ^ s[17] ^ s[14] ^ s[6] ^ s[1]};
    endfunction

    // Unroll SER_W LFSR steps to get this beat's reference UIs (earliest UI in bit 0).
    always_comb begin
        logic [LFSR_W-1:0] v_walk;
        v_walk = r_lfsr;
        w_ref  = '0;
        for (int k = 0; k < int'(SER_W); k++) begin
            w_ref[k] = v_walk[LFSR_W-1];
            v_walk   = lfsr_step(v_walk);
        end
        w_lfsr_next = v_walk;
    end

    // Per-lane mismatch popcount, saturating accumulation and pass decisions.
    always_comb begin
        logic [CNT_W-1:0] v_pop;
        logic [CNT_W:0]   v_sum;
        v_pop       = '0;
        v_sum       = '0;
        w_pass_next = '0;
        w_pass_cur  = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            v_pop = '0;
            for (int k = 0; k < int'(SER_W); k++) begin
                v_pop = v_pop + CNT_W'(i_rx_data[i*int'(SER_W) + k] ^ w_ref[k]);
            end
            v_sum          = {1'b0, r_err_cnt[i]} + {1'b0, v_pop};
            w_err_next[i]  = v_sum[CNT_W] ? {CNT_W{1'b1}} : v_sum[CNT_W-1:0];
            w_pass_next[i] = (w_err_next[i] <= CNT_W'(ERR_THRESH));
            w_pass_cur[i]  = (r_err_cnt[i] <= CNT_W'(ERR_THRESH));
        end
    end

    // Detect the beat that completes the window.
    always_comb begin
        w_beat_inc   = r_beat_cnt + BEAT_W'(1);
        w_window_end = (w_beat_inc == BEAT_W'(COMPARE_CYCLES));
    end

    // Control FSM with LFSR, counters and registered results; clear has priority over everything but reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_lfsr           <= LFSR_SEED;
            r_beat_cnt       <= '0;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                r_err_cnt[i] <= '0;
            end
            o_lane_result    <= '0;
            o_compare_done   <= 1'b0;
            o_aggregate_pass <= 1'b0;
        end else if (i_cw == CW_CLEAR) begin
            r_state          <= ST_CLEAR;
            r_lfsr           <= LFSR_SEED;
            r_beat_cnt       <= '0;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                r_err_cnt[i] <= '0;
            end
            o_lane_result    <= '0;
            o_compare_done   <= 1'b0;
            o_aggregate_pass <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cw == CW_COMPARE) begin
                        r_state <= ST_COMPARE;
                    end
                end
                ST_CLEAR: begin
                    if (i_cw == CW_COMPARE) begin
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (i_cw != CW_COMPARE) begin
                        // Early stop: report partial counts, this cycle's beat is ignored.
                        r_state          <= ST_DONE;
                        o_lane_result    <= w_pass_cur;
                        o_compare_done   <= 1'b1;
                        o_aggregate_pass <= &w_pass_cur;
                    end else if (i_rx_data_valid) begin
                        r_lfsr     <= w_lfsr_next;
                        r_beat_cnt <= w_beat_inc;
                        r_err_cnt  <= w_err_next;
                        if (w_window_end) begin
                            r_state          <= ST_DONE;
                            o_lane_result    <= w_pass_next;
                            o_compare_done   <= 1'b1;
                            o_aggregate_pass <= &w_pass_next;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb_lane_pattern_comparator.sv
// Scoreboard bench for mb_lane_pattern_comparator: directed windows, expected results queued at stimulus time.
module tb_mb_lane_pattern_comparator;

    localparam int NL = 16;
    localparam int SW = 8;
    localparam logic [22:0] SEED = 23'h1DBFBC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        cw;
    logic [NL*SW-1:0]  rx_data;
    logic              rx_valid;
    logic [NL-1:0]     lane_result;
    logic              compare_done;
    logic              aggregate_pass;

    mb_lane_pattern_comparator dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cw            (cw),
        .i_rx_data       (rx_data),
        .i_rx_data_valid (rx_valid),
        .o_lane_result   (lane_result),
        .o_compare_done  (compare_done),
        .o_aggregate_pass(aggregate_pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0] res;
        logic          agg;
        int            cyc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pcyc    = 0;
    logic [22:0] m_lfsr;
    logic [7:0]  corrupt [NL];
    bit          inv0;

    always @(posedge clk) pcyc <= pcyc + 1;

    function automatic logic [22:0] lfsr_step(input logic [22:0] s);
        return {s[21:0], s[22] ^ s[20] ^ s[17] ^ s[14] ^ s[6] ^ s[1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    // Monitor: on each rising edge of done, pop the expected window result and compare.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (compare_done === 1'b1 && !prev_done) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending window (cycle %0d)", pcyc);
            end else begin
                e = q.pop_front();
                check("lane_result", 32'(lane_result), 32'(e.res));
                check("aggregate_pass", 32'(aggregate_pass), 32'(e.agg));
                check("done_latency_cycle", 32'(pcyc), 32'(e.cyc));
            end
        end
        prev_done = (compare_done === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Next SER_W reference UIs from the bench's own LFSR model.
    task automatic next_ref(output logic [7:0] r);
        for (int k = 0; k < SW; k++) begin
            r[k]   = m_lfsr[22];
            m_lfsr = lfsr_step(m_lfsr);
        end
    endtask

    task automatic set_beat(input int b);
        logic [7:0]       r;
        logic [NL*SW-1:0] d;
        next_ref(r);
        for (int l = 0; l < NL; l++) begin
            d[l*SW +: SW] = r ^ ((b == 0) ? corrupt[l] : 8'h00) ^ ((inv0 && l == 0) ? 8'hFF : 8'h00);
        end
        rx_data  = d;
        rx_valid = 1'b1;
    endtask

    task automatic drive_window(input int nbeats, input bit gaps, input bit expect_end,
                                input logic [NL-1:0] exp_res);
        exp_t e;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                rx_valid = 1'b0;
                tick();
            end
            set_beat(b);
            if (expect_end && b == nbeats - 1) begin
                e.res = exp_res;
                e.agg = &exp_res;
                e.cyc = pcyc + 1;
                q.push_back(e);
            end
            tick();
        end
        rx_valid = 1'b0;
    endtask

    // Two clear cycles, then one cw=11 cycle to enter COMPARE before beats start.
    task automatic start_clear();
        rx_valid = 1'b0;
        cw = 2'b01;
        tick();
        tick();
        cw = 2'b11;
        tick();
        m_lfsr = SEED;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got done=%b expected done=1 within 20 cycles", compare_done);
            q.delete();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]       r;
        logic [NL*SW-1:0] d;
        exp_t             e;
        rst_n    = 1'b0;
        cw       = 2'b00;
        rx_valid = 1'b0;
        rx_data  = '0;
        inv0     = 1'b0;
        m_lfsr   = SEED;
        for (int l = 0; l < NL; l++) corrupt[l] = 8'h00;
        tick();
        tick();
        check("reset_outputs", {13'd0, compare_done, aggregate_pass, lane_result}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_outputs", {13'd0, compare_done, aggregate_pass, lane_result}, 32'h0);

        // 1: clean full window
        start_clear();
        drive_window(64, 1'b0, 1'b1, 16'hFFFF);
        wait_done();

        // 2: lane 3 gets 5 errors (fail), lane 7 gets 4 errors (pass at threshold)
        corrupt[3] = 8'h1F;
        corrupt[7] = 8'h0F;
        start_clear();
        drive_window(64, 1'b0, 1'b1, 16'hFFF7);
        wait_done();
        corrupt[3] = 8'h00;
        corrupt[7] = 8'h00;

        // 3: valid only every other cycle
        start_clear();
        drive_window(64, 1'b1, 1'b1, 16'hFFFF);
        wait_done();

        // 4: 10 beats with lane 0 inverted, then early stop; the stop-cycle beat is all-wrong and must be ignored
        start_clear();
        inv0 = 1'b1;
        drive_window(10, 1'b0, 1'b0, 16'h0000);
        inv0 = 1'b0;
        cw = 2'b00;
        next_ref(r);
        for (int l = 0; l < NL; l++) d[l*SW +: SW] = ~r;
        rx_data  = d;
        rx_valid = 1'b1;
        e.res = 16'hFFFE;
        e.agg = 1'b0;
        e.cyc = pcyc + 1;
        q.push_back(e);
        tick();
        rx_valid = 1'b0;
        wait_done();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("early_done_hold", {13'd0, compare_done, aggregate_pass, lane_result}, {13'd0, 1'b1, 1'b0, 16'hFFFE});
        end

        // 5: clear from DONE, then a fresh clean window, then cw=11 held in DONE
        cw = 2'b01;
        tick();
        check("clear_from_done", {13'd0, compare_done, aggregate_pass, lane_result}, 32'h0);
        cw = 2'b11;
        tick();
        m_lfsr = SEED;
        drive_window(64, 1'b0, 1'b1, 16'hFFFF);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            inv0 = 1'b1;
            set_beat(1);
            tick();
            check("done_hold_cw11", {13'd0, compare_done, aggregate_pass, lane_result}, {13'd0, 1'b1, 1'b1, 16'hFFFF});
        end
        inv0 = 1'b0;
        rx_valid = 1'b0;

        // 6: reset at beat 30, then restart from IDLE with the seed
        start_clear();
        drive_window(30, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b0;
        cw    = 2'b00;
        tick();
        rst_n = 1'b1;
        check("midwindow_reset", {13'd0, compare_done, aggregate_pass, lane_result}, 32'h0);
        tick();
        tick();
        check("post_reset_idle", {13'd0, compare_done, aggregate_pass, lane_result}, 32'h0);
        cw = 2'b11;
        tick();
        m_lfsr = SEED;
        drive_window(64, 1'b0, 1'b1, 16'hFFFF);
        wait_done();

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
